cache_controller: RTL and testbench

- Sequences trace commands (command_t) into the set-associative L1 cache array: read set, evaluate hit/miss, update MESI and LRU, write set back.
- Sits between the trace reader and the cache storage block, which has a one-cycle read and write port.
- Owns the clear sweep (n=8), the hit/miss/writeback reporting and the statistics counters.
- Never holds array contents beyond the single set in flight.

---
 rtl/cache_controller.sv | 219 +++++++++++++++++++++
 tb/tb_cache_controller.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// Set-associative L1 controller: reads one set, resolves hit/miss with MESI/LRU
// update, writes the set back; also runs the full-array clear sweep and keeps statistics.

typedef struct packed {
    logic [11:0] tag;
    logic [13:0] set_index;
    logic [5:0]  offset;
} address_t;

typedef struct packed {
    logic [3:0] n;
    address_t   address;
} command_t;

// lru is 3 bits wide, so associativity tops out at 8 ways.
typedef struct packed {
    logic [11:0] tag;
    logic [1:0]  mesi;
    logic [2:0]  lru;
    logic [15:0] data;
} cache_line_t;

module cache_controller #(
    parameter int sets = 16384,
    parameter int ways = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  command_t                      cmd,
    output logic [$clog2(sets)-1:0]       set_idx,
    output logic                          rd_en,
    input  cache_line_t [ways-1:0]        rd_line,
    output logic                          wr_en,
    output cache_line_t [ways-1:0]        wr_line,
    output logic                          done,
    output logic                          hit,
    output logic                          miss,
    output logic                          writeback,
    output logic [31:0]                   hit_count,
    output logic [31:0]                   miss_count
);

    localparam int SW = $clog2(sets);
    localparam int WW = (ways > 1) ? $clog2(ways) : 1;
    localparam logic [2:0] LRU_MAX = 3'(ways - 1);

    localparam logic [1:0] MESI_I = 2'd0;
    localparam logic [1:0] MESI_S = 2'd1;
    localparam logic [1:0] MESI_E = 2'd2;
    localparam logic [1:0] MESI_M = 2'd3;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RD    = 3'd1;
    localparam logic [2:0] ST_EVAL  = 3'd2;
    localparam logic [2:0] ST_WR    = 3'd3;
    localparam logic [2:0] ST_CLEAR = 3'd4;
    localparam logic [2:0] ST_ACK   = 3'd5;

    logic [2:0]             state_reg;
    command_t               cmd_reg;
    cache_line_t [ways-1:0] line_reg;
    logic                   hit_reg, miss_reg, wb_reg;
    logic [SW-1:0]          clr_reg;
    logic [31:0]            hit_count_reg, miss_count_reg;

    logic [ways-1:0]        hit_vec;
    logic                   hit_any;
    logic [WW-1:0]          hit_way, victim, touch_way;
    logic [2:0]             touch_old;
    cache_line_t [ways-1:0] touched, line_next, clear_line;
    logic                   wb_next;
    logic                   clr_last;
    logic                   unused_bits;

    assign clr_last    = (clr_reg == SW'(sets - 1));
    assign unused_bits = ^cmd_reg;

    genvar gi;
    generate
        for (gi = 0; gi < ways; gi++) begin : g_way
            assign hit_vec[gi] = (rd_line[gi].mesi != MESI_I) &&
                                 (rd_line[gi].tag == cmd_reg.address.tag);
            // Cleared set: LRU descending by way so way ways-1 is the first victim.
            assign clear_line[gi] = '{tag: 12'd0, mesi: MESI_I,
                                      lru: 3'(ways - 1 - gi), data: 16'(clr_reg)};
        end
    endgenerate

    assign hit_any = |hit_vec;

    always_comb begin
        hit_way = '0;
        victim  = '0;
        for (int k = 0; k < ways; k++) begin
            if (hit_vec[k]) hit_way = WW'(k);
            if (rd_line[k].lru == 3'd0) victim = WW'(k);
        end
    end

    assign touch_way = hit_any ? hit_way : victim;
    assign touch_old = rd_line[touch_way].lru;

    always_comb begin
        touched = rd_line;
        for (int k = 0; k < ways; k++) begin
            if (touch_way == WW'(k))
                touched[k].lru = LRU_MAX;
            else if (rd_line[k].lru > touch_old)
                touched[k].lru = rd_line[k].lru - 3'd1;
        end
    end

    always_comb begin
        line_next = rd_line;
        wb_next   = 1'b0;
        case (cmd_reg.n)
            4'd0, 4'd1, 4'd2: begin
                line_next = touched;
                if (hit_any) begin
                    if (cmd_reg.n == 4'd1) line_next[hit_way].mesi = MESI_M;
                end else begin
                    wb_next = (rd_line[victim].mesi == MESI_M);
                    line_next[victim].tag  = cmd_reg.address.tag;
                    line_next[victim].mesi = (cmd_reg.n == 4'd1) ? MESI_M : MESI_E;
                end
            end
            4'd3: begin
                if (hit_any) line_next[hit_way].mesi = MESI_I;
            end
            4'd4: begin
                if (hit_any && rd_line[hit_way].mesi == MESI_M) begin
                    wb_next = 1'b1;
                    line_next[hit_way].mesi = MESI_S;
                end else if (hit_any && rd_line[hit_way].mesi == MESI_E) begin
                    line_next[hit_way].mesi = MESI_S;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            clr_reg        <= '0;
            hit_reg        <= 1'b0;
            miss_reg       <= 1'b0;
            wb_reg         <= 1'b0;
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        clr_reg <= '0;
                        if (cmd.n == 4'd8)      state_reg <= ST_CLEAR;
                        else if (cmd.n <= 4'd4) state_reg <= ST_RD;
                        else                    state_reg <= ST_ACK;
                    end
                end
                ST_RD:   state_reg <= ST_EVAL;
                ST_EVAL: begin
                    hit_reg   <= hit_any;
                    miss_reg  <= !hit_any;
                    wb_reg    <= wb_next;
                    state_reg <= ST_WR;
                end
                ST_WR: begin
                    // Snoops and invalidates are reported but not counted.
                    if (cmd_reg.n <= 4'd2) begin
                        if (hit_reg && hit_count_reg != 32'hFFFF_FFFF)
                            hit_count_reg <= hit_count_reg + 32'd1;
                        if (miss_reg && miss_count_reg != 32'hFFFF_FFFF)
                            miss_count_reg <= miss_count_reg + 32'd1;
                    end
                    state_reg <= ST_IDLE;
                end
                ST_CLEAR: begin
                    if (clr_last) begin
                        hit_count_reg  <= '0;
                        miss_count_reg <= '0;
                        state_reg      <= ST_IDLE;
                    end else begin
                        clr_reg <= clr_reg + 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_reg == ST_IDLE && cmd_valid) cmd_reg <= cmd;
        if (state_reg == ST_EVAL) line_reg <= line_next;
    end

    assign cmd_ready  = (state_reg == ST_IDLE);
    assign rd_en      = (state_reg == ST_RD);
    assign wr_en      = (state_reg == ST_WR) || (state_reg == ST_CLEAR);
    assign done       = (state_reg == ST_WR) || (state_reg == ST_ACK) ||
                        (state_reg == ST_CLEAR && clr_last);
    assign hit        = (state_reg == ST_WR) && hit_reg;
    assign miss       = (state_reg == ST_WR) && miss_reg;
    assign writeback  = (state_reg == ST_WR) && wb_reg;
    assign wr_line    = (state_reg == ST_CLEAR) ? clear_line : line_reg;
    assign hit_count  = hit_count_reg;
    assign miss_count = miss_count_reg;

    always_comb begin
        set_idx = '0;
        if (state_reg == ST_CLEAR)
            set_idx = clr_reg;
        else if (state_reg == ST_RD || state_reg == ST_EVAL || state_reg == ST_WR)
            set_idx = cmd_reg.address.set_index[SW-1:0];
    end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller (16 sets, 4 ways) with a one-cycle set array model.

module tb_cache_controller;

    localparam int SETS = 16;
    localparam int WAYS = 4;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   cmd_valid;
    logic                   cmd_ready;
    command_t               cmd;
    logic [3:0]             set_idx;
    logic                   rd_en, wr_en, done, hit, miss, writeback;
    cache_line_t [WAYS-1:0] rd_line, wr_line;
    logic [31:0]            hit_count, miss_count;

    cache_line_t [WAYS-1:0] mem [SETS];

    int tests = 0;
    int fails = 0;

    // Per-command observations
    int rd_cyc, wr_cyc, done_cyc, n_rd, n_wr, seq_bad, busy_rdy, stray;
    logic f_hit, f_miss, f_wb;

    cache_controller #(.sets(SETS), .ways(WAYS)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd(cmd), .set_idx(set_idx), .rd_en(rd_en), .rd_line(rd_line),
        .wr_en(wr_en), .wr_line(wr_line), .done(done), .hit(hit), .miss(miss),
        .writeback(writeback), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_en) mem[set_idx] <= wr_line;
        if (rd_en) rd_line <= mem[set_idx];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic sample(input int c);
        if (rd_en) begin
            n_rd++;
            if (rd_cyc == 0) rd_cyc = c;
        end
        if (wr_en) begin
            if (set_idx != 4'(n_wr)) seq_bad++;
            n_wr++;
            if (wr_cyc == 0) wr_cyc = c;
        end
        if (cmd_ready) busy_rdy++;
        if (done) begin
            done_cyc = c;
            f_hit = hit;
            f_miss = miss;
            f_wb = writeback;
        end else if (hit || miss || writeback) begin
            stray++;
        end
    endtask

    task automatic issue(input logic [3:0] n, input logic [11:0] tag, input int set);
        @(negedge clk);
        cmd = '0;
        cmd.n = n;
        cmd.address.tag = tag;
        cmd.address.set_index = 14'(set);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        rd_cyc = 0; wr_cyc = 0; done_cyc = 0; n_rd = 0; n_wr = 0;
        seq_bad = 0; busy_rdy = 0;
        f_hit = 1'b0; f_miss = 1'b0; f_wb = 1'b0;
    endtask

    task automatic run_cmd(input logic [3:0] n, input logic [11:0] tag, input int set);
        issue(n, tag, set);
        for (int c = 1; c <= 64; c++) begin
            sample(c);
            if (done_cyc != 0) break;
            @(posedge clk);
            #1;
        end
        if (done_cyc == 0) check("done_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int found;
        int late_wr, late_done;
        stray = 0;
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_rd_wr_done", 64'({rd_en, wr_en, done}), 64'd0);
        check("rst_flags", 64'({hit, miss, writeback}), 64'd0);
        check("rst_set_idx", 64'(set_idx), 64'd0);
        check("rst_counts", {hit_count, miss_count}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // 1: clear sweep
        run_cmd(4'd8, 12'h0, 0);
        check("clr_wr_count", 64'(n_wr), 64'd16);
        check("clr_first_wr", 64'(wr_cyc), 64'd1);
        check("clr_done_cyc", 64'(done_cyc), 64'd16);
        check("clr_no_rd", 64'(n_rd), 64'd0);
        check("clr_set_seq", 64'(seq_bad), 64'd0);
        check("clr_busy_ready", 64'(busy_rdy), 64'd0);
        check("clr_lru_set9", {mem[9][0].lru, mem[9][1].lru, mem[9][2].lru, mem[9][3].lru},
              {3'd3, 3'd2, 3'd1, 3'd0});
        check("clr_mesi_set9", 64'(mem[9][2].mesi), 64'd0);
        check("clr_data_set9", 64'(mem[9][1].data), 64'd9);
        check("clr_lru_set15", 64'(mem[15][1].lru), 64'd2);
        check("clr_counts", {hit_count, miss_count}, 64'd0);

        // 2: read miss allocates into way 3
        run_cmd(4'd0, 12'hA, 5);
        check("rd_miss_rd_cyc", 64'(rd_cyc), 64'd1);
        check("rd_miss_wr_cyc", 64'(wr_cyc), 64'd3);
        check("rd_miss_done_cyc", 64'(done_cyc), 64'd3);
        check("rd_miss_flags", 64'({f_hit, f_miss, f_wb}), 64'b010);
        check("rd_miss_way3", 64'({mem[5][3].tag, mem[5][3].mesi, mem[5][3].lru}),
              64'({12'hA, 2'd2, 3'd3}));
        check("rd_miss_lru012", {mem[5][0].lru, mem[5][1].lru, mem[5][2].lru},
              {3'd2, 3'd1, 3'd0});
        check("rd_miss_counts", {hit_count, miss_count}, {32'd0, 32'd1});

        // 3: write hit
        run_cmd(4'd1, 12'hA, 5);
        check("wr_hit_flags", 64'({f_hit, f_miss, f_wb}), 64'b100);
        check("wr_hit_way3", 64'({mem[5][3].mesi, mem[5][3].lru}), 64'({2'd3, 3'd3}));
        check("wr_hit_counts", {hit_count, miss_count}, {32'd1, 32'd1});

        // 4: fill set 5, then evict the modified line
        run_cmd(4'd0, 12'hB, 5);
        check("fill_b_flags", 64'({f_hit, f_miss, f_wb}), 64'b010);
        run_cmd(4'd0, 12'hC, 5);
        check("fill_c_flags", 64'({f_hit, f_miss, f_wb}), 64'b010);
        run_cmd(4'd0, 12'hD, 5);
        check("fill_d_flags", 64'({f_hit, f_miss, f_wb}), 64'b010);
        check("fill_d_lru", {mem[5][0].lru, mem[5][1].lru, mem[5][2].lru, mem[5][3].lru},
              {3'd3, 3'd2, 3'd1, 3'd0});
        run_cmd(4'd0, 12'hE, 5);
        check("evict_flags", 64'({f_hit, f_miss, f_wb}), 64'b011);
        check("evict_way3", 64'({mem[5][3].tag, mem[5][3].mesi}), 64'({12'hE, 2'd2}));
        check("evict_counts", {hit_count, miss_count}, {32'd1, 32'd5});

        // 5: write miss, snoop read, invalidate
        run_cmd(4'd1, 12'h7, 2);
        check("wmiss_flags", 64'({f_hit, f_miss, f_wb}), 64'b010);
        check("wmiss_mesi", 64'(mem[2][3].mesi), 64'd3);
        run_cmd(4'd4, 12'h7, 2);
        check("snoop_flags", 64'({f_hit, f_miss, f_wb}), 64'b101);
        check("snoop_line", 64'({mem[2][3].mesi, mem[2][3].lru, mem[2][0].lru}),
              64'({2'd1, 3'd3, 3'd2}));
        run_cmd(4'd3, 12'h7, 2);
        check("inval_flags", 64'({f_hit, f_miss, f_wb}), 64'b100);
        check("inval_mesi", 64'(mem[2][3].mesi), 64'd0);
        check("inval_counts", {hit_count, miss_count}, {32'd1, 32'd6});
        run_cmd(4'd4, 12'h7, 2);
        check("snoop_miss_flags", 64'({f_hit, f_miss, f_wb}), 64'b010);

        // 6: reset in the middle of a clear sweep
        issue(4'd8, 12'h0, 0);
        found = 0;
        for (int c = 1; c <= 40; c++) begin
            if (wr_en && set_idx == 4'd7) begin
                found = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("abort_reached_set7", 64'(found), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_wr_en", 64'(wr_en), 64'd0);
        check("abort_cmd_ready", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        late_wr = 0;
        late_done = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (wr_en) late_wr++;
            if (done) late_done++;
        end
        check("abort_late_wr_done", 64'({late_wr[15:0], late_done[15:0]}), 64'd0);
        check("abort_counts", {hit_count, miss_count}, 64'd0);

        // unsupported command
        run_cmd(4'd9, 12'h1, 3);
        check("nop_done_cyc", 64'(done_cyc), 64'd1);
        check("nop_rd_wr", 64'({n_rd[15:0], n_wr[15:0]}), 64'd0);
        check("nop_flags", 64'({f_hit, f_miss, f_wb}), 64'd0);

        check("flags_outside_done", 64'(stray), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
